// File: rtl/header_pkg.sv
// Shared types, bitrate/sample-rate tables and per-layer constants
// for the MPEG-1 audio frame-header parser.
package header_pkg;

  typedef enum logic [1:0] {
    LAYER_RSV = 2'b00,
    LAYER_3   = 2'b01,
    LAYER_2   = 2'b10,
    LAYER_1   = 2'b11
  } layer_e;

  typedef enum logic [1:0] {
    MODE_STEREO = 2'b00,
    MODE_JOINT  = 2'b01,
    MODE_DUAL   = 2'b10,
    MODE_MONO   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_SYNC0,
    S_SYNC1,
    S_B2,
    S_B3
  } hdr_state_e;

  localparam logic [8:0] BR_L1 [16] = '{
    9'd0,   9'd32,  9'd64,  9'd96,
    9'd128, 9'd160, 9'd192, 9'd224,
    9'd256, 9'd288, 9'd320, 9'd352,
    9'd384, 9'd416, 9'd448, 9'd0
  };

  localparam logic [8:0] BR_L2 [16] = '{
    9'd0,   9'd32,  9'd48,  9'd56,
    9'd64,  9'd80,  9'd96,  9'd112,
    9'd128, 9'd160, 9'd192, 9'd224,
    9'd256, 9'd320, 9'd384, 9'd0
  };

  localparam logic [8:0] BR_L3 [16] = '{
    9'd0,   9'd32,  9'd40,  9'd48,
    9'd56,  9'd64,  9'd80,  9'd96,
    9'd112, 9'd128, 9'd160, 9'd192,
    9'd224, 9'd256, 9'd320, 9'd0
  };

  localparam logic [15:0] SR_TAB [4] = '{
    16'd44100, 16'd48000, 16'd32000, 16'd0
  };

  localparam logic [8:0] FS_L1  = 9'd12;
  localparam logic [8:0] FS_L23 = 9'd144;
  localparam logic [2:0] SS_L1  = 3'd4;
  localparam logic [2:0] SS_L23 = 3'd1;

  function automatic logic [8:0] br_lookup(
    input layer_e     lay,
    input logic [3:0] idx
  );
    case (lay)
      LAYER_1: return BR_L1[idx];
      LAYER_2: return BR_L2[idx];
      default: return BR_L3[idx];
    endcase
  endfunction

endpackage

// File: rtl/frame_div.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// start loads operands (and aborts any run); done pulses one cycle.
module frame_div #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [15:0]      divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(DIV_W + 1);

  logic [CW-1:0] cnt;
  logic          busy;
  logic [15:0]   rem;
  logic [15:0]   dsr;
  logic [16:0]   shl;
  logic [15:0]   diff;
  logic          fit;

  // Remainder stays below the divisor, so the difference fits 16 bits.
  assign shl  = {rem, quotient[DIV_W-1]};
  assign fit  = shl >= {1'b0, dsr};
  assign diff = shl[15:0] - dsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      busy     <= 1'b0;
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        cnt      <= '0;
        rem      <= '0;
        dsr      <= divisor;
        quotient <= dividend;
      end else if (busy) begin
        if (cnt == CW'(DIV_W)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt      <= cnt + 1'b1;
          rem      <= fit ? diff : shl[15:0];
          quotient <= {quotient[DIV_W-2:0], fit};
        end
      end
    end
  end

endmodule

// File: rtl/header_parser.sv
// Streaming MPEG-1 audio frame-header parser with frame-length divider.
// Optional HEADER_STRICT_EN rejects reserved emphasis and bad L2 combos.
module header_parser
  import header_pkg::*;
#(
  parameter int DIV_W = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  axiid,
  input  logic        axiiv,
  output logic        axiov,
  output logic        prot,
  output logic [8:0]  bitrate,
  output logic [15:0] samp_rate,
  output logic        padding,
  output logic        private,
  output logic [1:0]  mode,
  output logic [1:0]  mode_ext,
  output logic [1:0]  emphasis,
  output logic [8:0]  frame_sample,
  output logic [2:0]  slot_size,
  output logic [10:0] frame_size
);

  hdr_state_e state, state_nx;
  logic [4:0] b1;
  logic [7:0] b2;

  layer_e     lay;
  logic [8:0] br_kbps;
  logic [15:0] sr_hz;
  logic [8:0] fsamp;
  logic [2:0] slot;
  logic       hdr_ok;
  logic       start;
  logic       resync;

  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] quo;
  logic             div_done;
  logic [DIV_W+2:0] fs_full;

  logic        p_prot, p_pad, p_priv;
  logic [8:0]  p_br, p_fs;
  logic [15:0] p_sr;
  logic [1:0]  p_mode, p_mext, p_emph;
  logic [2:0]  p_slot;

  assign lay     = layer_e'(b1[2:1]);
  assign br_kbps = br_lookup(lay, b2[7:4]);
  assign sr_hz   = SR_TAB[b2[3:2]];
  assign fsamp   = (lay == LAYER_1) ? FS_L1 : FS_L23;
  assign slot    = (lay == LAYER_1) ? SS_L1 : SS_L23;

  // An FF byte1 followed by another sync-looking byte: the FF was
  // really a sync byte, so slide the window forward by one.
  assign resync = (b1 == 5'h1F) && (axiid[7:5] == 3'b111);

  always_comb begin
    hdr_ok = (b1[4:3] == 2'b11) &&
             (lay != LAYER_RSV) &&
             (b2[7:4] != 4'h0) &&
             (b2[7:4] != 4'hF) &&
             (b2[3:2] != 2'b11);
`ifdef HEADER_STRICT_EN
    if (axiid[1:0] == 2'b10)
      hdr_ok = 1'b0;
    if (lay == LAYER_2) begin
      if (mode_e'(axiid[7:6]) == MODE_MONO) begin
        if (br_kbps > 9'd192)
          hdr_ok = 1'b0;
      end else begin
        if (br_kbps == 9'd32 || br_kbps == 9'd48 ||
            br_kbps == 9'd56 || br_kbps == 9'd80)
          hdr_ok = 1'b0;
      end
    end
`endif
  end

  assign start = axiiv && (state == S_B3) && hdr_ok;

  assign dividend = DIV_W'(fsamp) * DIV_W'(br_kbps) *
                    DIV_W'(10'd1000);

  always_comb begin
    state_nx = state;
    if (axiiv) begin
      unique case (state)
        S_SYNC0: if (axiid == 8'hFF) state_nx = S_SYNC1;
        S_SYNC1: state_nx = (axiid[7:5] == 3'b111) ? S_B2 : S_SYNC0;
        S_B2:    if (!resync) state_nx = S_B3;
        S_B3:    state_nx = S_SYNC0;
        default: state_nx = S_SYNC0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_SYNC0;
      b1    <= '0;
      b2    <= '0;
    end else begin
      state <= state_nx;
      if (axiiv && state == S_SYNC1 && axiid[7:5] == 3'b111)
        b1 <= axiid[4:0];
      if (axiiv && state == S_B2) begin
        if (resync) b1 <= axiid[4:0];
        else        b2 <= axiid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_prot <= 1'b0;
      p_br   <= '0;
      p_sr   <= '0;
      p_pad  <= 1'b0;
      p_priv <= 1'b0;
      p_mode <= '0;
      p_mext <= '0;
      p_emph <= '0;
      p_fs   <= '0;
      p_slot <= '0;
    end else if (start) begin
      p_prot <= b1[0];
      p_br   <= br_kbps;
      p_sr   <= sr_hz;
      p_pad  <= b2[1];
      p_priv <= b2[0];
      p_mode <= axiid[7:6];
      p_mext <= axiid[5:4];
      p_emph <= axiid[1:0];
      p_fs   <= fsamp;
      p_slot <= slot;
    end
  end

  frame_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dividend(dividend),
    .divisor (sr_hz),
    .quotient(quo),
    .done    (div_done)
  );

  assign fs_full = ((DIV_W+3)'(quo) + (DIV_W+3)'(p_pad)) *
                   (DIV_W+3)'(p_slot);

  always_ff @(posedge clk) begin
    if (rst) begin
      axiov        <= 1'b0;
      prot         <= 1'b0;
      bitrate      <= '0;
      samp_rate    <= '0;
      padding      <= 1'b0;
      private      <= 1'b0;
      mode         <= '0;
      mode_ext     <= '0;
      emphasis     <= '0;
      frame_sample <= '0;
      slot_size    <= '0;
      frame_size   <= '0;
    end else begin
      axiov <= div_done;
      if (div_done) begin
        prot         <= p_prot;
        bitrate      <= p_br;
        samp_rate    <= p_sr;
        padding      <= p_pad;
        private      <= p_priv;
        mode         <= p_mode;
        mode_ext     <= p_mext;
        emphasis     <= p_emph;
        frame_sample <= p_fs;
        slot_size    <= p_slot;
        frame_size   <= (|fs_full[DIV_W+2:11]) ? '1 : fs_full[10:0];
      end
    end
  end

endmodule

// File: tb/tb_header_parser.sv
// Randomized self-checking bench for header_parser against a
// table-driven header model; honours HEADER_STRICT_EN.
module tb_header_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  axiid = '0;
  logic        axiiv = 1'b0;
  logic        axiov;
  logic        prot;
  logic [8:0]  bitrate;
  logic [15:0] samp_rate;
  logic        padding;
  logic        private;
  logic [1:0]  mode;
  logic [1:0]  mode_ext;
  logic [1:0]  emphasis;
  logic [8:0]  frame_sample;
  logic [2:0]  slot_size;
  logic [10:0] frame_size;

  header_parser dut (
    .clk         (clk),
    .rst         (rst),
    .axiid       (axiid),
    .axiiv       (axiiv),
    .axiov       (axiov),
    .prot        (prot),
    .bitrate     (bitrate),
    .samp_rate   (samp_rate),
    .padding     (padding),
    .private     (private),
    .mode        (mode),
    .mode_ext    (mode_ext),
    .emphasis    (emphasis),
    .frame_sample(frame_sample),
    .slot_size   (slot_size),
    .frame_size  (frame_size)
  );

  always #5 clk = ~clk;

  logic [56:0] fields;
  assign fields = {prot, bitrate, samp_rate, padding, private, mode,
                   mode_ext, emphasis, frame_sample, slot_size,
                   frame_size};

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int br1 [16] = '{0, 32, 64, 96, 128, 160, 192, 224, 256, 288,
                   320, 352, 384, 416, 448, 0};
  int br2 [16] = '{0, 32, 48, 56, 64, 80, 96, 112, 128, 160,
                   192, 224, 256, 320, 384, 0};
  int br3 [16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128,
                   160, 192, 224, 256, 320, 0};
  int srt [4]  = '{44100, 48000, 32000, 0};

  function automatic int kbps(input logic [7:0] a, input logic [7:0] b);
    int lay = int'(a[2:1]);
    if (lay == 3) return br1[b[7:4]];
    if (lay == 2) return br2[b[7:4]];
    return br3[b[7:4]];
  endfunction

  function automatic bit hdr_valid(input logic [7:0] a, b, c);
    bit ok;
    int br;
    ok = a[4:3] == 2'b11 && a[2:1] != 0 && b[7:4] != 0 &&
         b[7:4] != 15 && b[3:2] != 3;
    br = kbps(a, b);
`ifdef HEADER_STRICT_EN
    if (c[1:0] == 2'b10) ok = 0;
    if (a[2:1] == 2'b10) begin
      if (c[7:6] == 2'b11 && br > 192) ok = 0;
      if (c[7:6] != 2'b11 &&
          (br == 32 || br == 48 || br == 56 || br == 80)) ok = 0;
    end
`else
    if (c == 8'h00 && br < 0) ok = 0;
`endif
    return ok;
  endfunction

  function automatic logic [56:0] hdr_fields(input logic [7:0] a, b, c);
    int br, sr, fsc, sl;
    longint q, fsz;
    br  = kbps(a, b);
    sr  = srt[b[3:2]];
    fsc = (a[2:1] == 2'b11) ? 12 : 144;
    sl  = (a[2:1] == 2'b11) ? 4 : 1;
    q   = (longint'(fsc) * br * 1000) / sr;
    fsz = (q + longint'(b[1])) * sl;
    return {a[0], 9'(br), 16'(sr), b[1], b[0], c[7:6], c[5:4],
            c[1:0], 9'(fsc), 3'(sl), 11'(fsz)};
  endfunction

  // Reference: sliding sync hunt, pulse scheduled 28 edges after byte 4.
  int          cyc = 0;
  int          ph = 0;
  logic [7:0]  h1, h2;
  int          pend = -1;
  logic [56:0] pend_f = '0;
  logic [56:0] exp_f = '0;
  bit          pulse_now = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    cyc++;
    pulse_now = 0;
    if (rst) begin
      ph = 0;
      pend = -1;
      exp_f = '0;
    end else begin
      if (cyc == pend) begin
        pulse_now = 1;
        exp_f = pend_f;
        pend = -1;
      end
      if (axiiv) begin
        case (ph)
          0: if (axiid == 8'hFF) ph = 1;
          1: if (axiid[7:5] == 3'b111) begin h1 = axiid; ph = 2; end
             else ph = 0;
          2: if (h1 == 8'hFF && axiid[7:5] == 3'b111) h1 = axiid;
             else begin h2 = axiid; ph = 3; end
          default: begin
            ph = 0;
            if (hdr_valid(h1, h2, axiid)) begin
              pend = cyc + 28;
              pend_f = hdr_fields(h1, h2, axiid);
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("axiov", 64'(axiov), 64'(pulse_now));
      check("fields", 64'(fields), 64'(exp_f));
    end
  end

  int last_cyc = 0;

  task automatic send_byte(input logic [7:0] b, input int gap);
    axiid = b;
    axiiv = 1'b1;
    @(negedge clk);
    axiiv = 1'b0;
    last_cyc = cyc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [31:0] h, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(h[i*8 +: 8], gap);
  endtask

  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (axiov) begin
        lat = cyc - last_cyc;
        break;
      end
    end
  endtask

  int lat;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_fields", 64'(fields), 64'd0);
    check("rst_axiov", 64'(axiov), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    send_byte(8'hFF, 5);
    send_byte(8'hFB, 5);
    send_byte(8'h92, 5);
    send_byte(8'h64, 0);
    wait_pulse(lat);
    check("lat1", 64'(lat), 64'd28);
    check("fsz1", 64'(frame_size), 64'd418);
    check("br1", 64'(bitrate), 64'd128);
    check("sr1", 64'(samp_rate), 64'd44100);
    check("mode1", 64'({prot, padding, private, mode, mode_ext, emphasis}),
          64'b110_01_10_00);
    check("fs_slot1", 64'({frame_sample, slot_size}), 64'({9'd144, 3'd1}));

    repeat (15) @(negedge clk);
    send_hdr(32'hFFFB9264, 0);
    wait_pulse(lat);
    check("lat2", 64'(lat), 64'd28);
    check("fsz2", 64'(frame_size), 64'd418);
    @(negedge clk);
    check("single", 64'(axiov), 64'd0);

    send_hdr(32'hFFFB9000, 2);
    wait_pulse(lat);
    check("fsz3", 64'(frame_size), 64'd417);
    check("mp3", 64'({mode, padding}), 64'd0);

    send_hdr(32'hFFFFC400, 1);
    wait_pulse(lat);
    check("l1", 64'({bitrate, samp_rate, frame_sample, slot_size}),
          64'({9'd384, 16'd48000, 9'd12, 3'd4}));
    check("fsz_l1", 64'(frame_size), 64'd384);

    send_hdr(32'hFFFDAA00, 1);
    wait_pulse(lat);
    check("l2", 64'({bitrate, samp_rate}), 64'({9'd192, 16'd32000}));
    check("fsz_l2", 64'(frame_size), 64'd865);

    send_byte(8'h12, 1);
    send_byte(8'hFF, 1);
    send_hdr(32'hFFFB9264, 1);
    wait_pulse(lat);
    check("resync_lat", 64'(lat), 64'd28);
    check("resync_fsz", 64'(frame_size), 64'd418);

    send_hdr(32'hFFFBF264, 1);
    wait_pulse(lat);
    check("bad_none", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    check("bad_hold", 64'(frame_size), 64'd418);

    send_byte(8'hFF, 1);
    send_byte(8'hFB, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h92, 1);
    send_byte(8'h64, 1);
    wait_pulse(lat);
    check("rst_none", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_zero", 64'(fields), 64'd0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [7:0] a, b, c;
      kind = int'($urandom_range(0, 99));
      if (kind < 8) begin
        send_byte(8'($urandom), int'($urandom_range(0, 3)));
      end else if (kind < 12) begin
        rst = 1'b1;
        repeat (int'($urandom_range(1, 2))) @(negedge clk);
        rst = 1'b0;
      end else begin
        int g;
        g = (kind < 60) ? int'($urandom_range(0, 2))
                        : int'($urandom_range(0, 9));
        if ($urandom_range(0, 4) != 0)
          a = {5'b11111, 2'($urandom_range(1, 3)), 1'($urandom)};
        else
          a = {3'b111, 5'($urandom)};
        if ($urandom_range(0, 4) != 0)
          b = {4'($urandom_range(1, 14)), 2'($urandom_range(0, 2)),
               2'($urandom)};
        else
          b = 8'($urandom);
        c = 8'($urandom);
        send_byte(8'hFF, g);
        send_byte(a, g);
        send_byte(b, g);
        send_byte(c, int'($urandom_range(0, 40)));
      end
    end
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
